mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 115 +++++++++++
 tb/tb_mult_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Fixed latency: mult/multu 5 cycles, div/divu 10 cycles.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic        RDsel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Out,
  output logic        Busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b;
  logic [31:0] uq, ur, quo, rem;
  logic [63:0] prod;

  // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    neg_a = ~op_q[0] & a_q[31];
    neg_b = ~op_q[0] & b_q[31];
    abs_a = neg_a ? (~a_q + 32'd1) : a_q;
    abs_b = neg_b ? (~b_q + 32'd1) : b_q;
    uq    = '0;
    ur    = '0;
    if (abs_b != 32'd0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    quo  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem  = neg_a ? (~ur + 32'd1) : ur;
    prod = {{32{neg_a}}, a_q} * {{32{neg_b}}, b_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          unique case (1'b1)
            (Op[2] == 1'b0): begin
              a_d     = A;
              b_d     = B;
              op_d    = Op[1:0];
              cnt_d   = Op[1] ? 4'd10 : 4'd5;
              state_d = RUN;
            end
            (Op == 3'd4): hi_d = A;
            (Op == 3'd5): lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign Out  = RDsel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO
// and busy length; monitor checks on Busy fall or on an explicit probe.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Op;
  logic        RDsel;
  logic [31:0] A, B;
  logic [31:0] Out;
  logic        Busy;
  logic        chk_req;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .Op    (Op),
    .RDsel (RDsel),
    .A     (A),
    .B     (B),
    .Out   (Out),
    .Busy  (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: sample on falling edge, drive RDsel inside the low phase.
  initial begin
    int   run;
    logic prev;
    exp_t e;
    run   = 0;
    prev  = 1'b0;
    RDsel = 1'b0;
    forever begin
      @(negedge clk);
      if (Busy === 1'b1) begin
        run++;
      end else begin
        if (prev || chk_req) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got output, want none");
          end else begin
            e = q.pop_front();
            check("busy_len", run, e.len);
            RDsel = 1'b1;
            #1 check("hi", Out, e.hi);
            RDsel = 1'b0;
            #1 check("lo", Out, e.lo);
          end
        end
        run = 0;
      end
      prev = (Busy === 1'b1);
    end
  end

  task automatic expect_r(input logic [31:0] hi, input logic [31:0] lo,
                          input int len);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.len = len;
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    #1;
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi,
                        input logic [31:0] lo, input int n);
    expect_r(hi, lo, n);
    issue(op, a, b);
    repeat (n + 1) @(posedge clk);
  endtask

  task automatic probe(input logic [31:0] hi, input logic [31:0] lo);
    expect_r(hi, lo, 0);
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    Start   = 1'b0;
    Op      = '0;
    A       = '0;
    B       = '0;
    chk_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    probe(32'h0, 32'h0);

    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 5);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);

    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    probe(32'h11, 32'h22);
    run_op(3'd3, 32'd7, 32'd0, 32'h11, 32'h22, 10);
    run_op(3'd2, 32'd7, 32'd0, 32'h11, 32'h22, 10);

    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF,
           32'h00000000, 32'h80000000, 10);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
    run_op(3'd0, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 5);

    // Start during RUN is dropped; mult result and timing unaffected.
    expect_r(32'h0, 32'd42, 5);
    issue(3'd0, 32'd6, 32'd7);
    @(posedge clk);
    #1;
    Start = 1'b1;
    Op    = 3'd2;
    A     = 32'd100;
    B     = 32'd3;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (5) @(posedge clk);

    issue(3'd4, 32'h12345678, 32'h0);
    issue(3'd5, 32'h9ABCDEF0, 32'h0);
    probe(32'h12345678, 32'h9ABCDEF0);
    issue(3'd6, 32'hDEADBEEF, 32'h1);
    issue(3'd7, 32'hDEADBEEF, 32'h1);
    probe(32'h12345678, 32'h9ABCDEF0);

    // Reset wins over a simultaneous mthi.
    @(posedge clk);
    #1;
    reset = 1'b0;
    Start = 1'b1;
    Op    = 3'd4;
    A     = 32'h5;
    @(posedge clk);
    #1;
    reset = 1'b1;
    Start = 1'b0;
    probe(32'h0, 32'h0);

    issue(3'd4, 32'hAAAA5555, 32'h0);
    expect_r(32'h0, 32'h0, 4);
    issue(3'd2, 32'hFFFFFF9C, 32'd7);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    run_op(3'd0, 32'd2, 32'd3, 32'd0, 32'd6, 5);

    repeat (3) @(posedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
